block_sync_rx: RTL and testbench
================================

BLOCK_SYNC_RX -- requirements
Module: block_sync_rx

Interface
REQ-001 Parameter HEAD_W, default 2, sync header width.
REQ-002 Parameter SH_CNT_MAX, default 64, headers per test window.
REQ-003 Parameter SH_INVALID_MAX, default 16, invalid headers per window that force loss of lock.
REQ-004 Parameter SLIP_WAIT_N, default 2, valid headers discarded after each slip.
REQ-005 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port valid_i, input, 1, head_i carries a new header this cycle; driven from the gearbox valid output.
REQ-008 Port head_i, input, HEAD_W, sync header from the gearbox.
REQ-009 Port slip_v_o, output, 1, one-cycle bit-slip request to the gearbox slip input.
REQ-010 Port lock_v_o, output, 1, block lock; drives the gearbox lock input and the downstream descrambler/decoder.

Function
REQ-011 The block SHALL implement the clause-49 block-lock function with FSM states TEST, SLIP and SLIP_WAIT.
REQ-012 A header SHALL be valid when head_i[0] XOR head_i[1] is 1 (2'b01 or 2'b10); 2'b00 and 2'b11 are invalid.
REQ-013 When valid_i is 0, state, counters and outputs SHALL hold; head_i is ignored.
REQ-014 Counters: sh_cnt, $clog2(SH_CNT_MAX+1) bits; sh_inv_cnt, $clog2(SH_INVALID_MAX+1) bits; neither SHALL wrap.
REQ-015 In TEST, each valid_i SHALL increment sh_cnt and, if the header is invalid, increment sh_inv_cnt.
REQ-016 An invalid header while lock_v_o=0, or one that takes sh_inv_cnt to SH_INVALID_MAX, SHALL send TEST to SLIP.
REQ-017 On that same edge, lock_v_o SHALL clear and both counters SHALL clear.
REQ-018 Otherwise, when sh_cnt reaches SH_CNT_MAX with sh_inv_cnt=0, lock_v_o SHALL be set on that edge and both counters SHALL clear.
REQ-019 Otherwise, when sh_cnt reaches SH_CNT_MAX with sh_inv_cnt>0 and lock held, both counters SHALL clear and lock_v_o SHALL stay 1.
REQ-020 Rule 016 SHALL take priority over rules 018/019 when both hit on the same header.
REQ-021 SLIP SHALL last exactly one cycle with slip_v_o=1, regardless of valid_i, then go to SLIP_WAIT.
REQ-022 slip_v_o SHALL be 1 only in SLIP, and therefore never high on two consecutive cycles.
REQ-023 SLIP_WAIT SHALL discard SLIP_WAIT_N valid headers, counting only cycles with valid_i=1, then enter TEST with both counters at 0.
REQ-024 All outputs SHALL be registered.
REQ-025 lock_v_o latency SHALL be one cycle after the edge that samples the deciding header.

Reset
REQ-026 While reset=1, at each clk edge the FSM SHALL go to TEST, counters to 0, lock_v_o to 0 and slip_v_o to 0.
REQ-027 Reset asserted mid-window or during SLIP/SLIP_WAIT SHALL abort the operation with no residual slip pulse.

Configuration
REQ-028 With macro BLOCK_SYNC_SLIP_CNT_EN defined, the block SHALL add output slip_cnt_o, 8 bits, counting slip_v_o pulses since reset.
REQ-029 slip_cnt_o SHALL saturate at 255 and reset to 0.
REQ-030 Without BLOCK_SYNC_SLIP_CNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 A shared PCS package SHALL hold the FSM state enum, the SH_CNT_MAX/SH_INVALID_MAX defaults and the valid-header encodings (2'b01 data, 2'b10 control).
REQ-032 The header window counters SHALL be one sub-module, sh_window_cnt, reporting window-done and invalid-limit flags; the FSM stays in block_sync_rx.

Verification
REQ-033 Bench: reset, then 64 valid headers of 2'b01 -> lock_v_o=1 the cycle after the 64th; slip_v_o never 1.
REQ-034 Bench: reset, first header 2'b11 -> slip_v_o=1 for exactly one cycle; next 2 valid headers ignored; lock_v_o stays 0.
REQ-035 Bench: locked, 15 invalid headers spread over a 64-header window -> lock_v_o stays 1, counters clear; 16 invalid in one window -> lock_v_o=0 and one slip pulse.
REQ-036 Bench: gearbox-style valid_i gaps (valid_i=0 one cycle in 33) during lock acquisition -> lock still after exactly 64 valid headers; state frozen in gaps.
REQ-037 Bench: reset=1 asserted in the SLIP cycle and after 30 headers -> next cycle lock_v_o=0, slip_v_o=0; fresh 64 good headers are needed for lock.
REQ-038 Bench: with BLOCK_SYNC_SLIP_CNT_EN, 300 forced slips -> slip_cnt_o=255.

Source files
------------

// File: rtl/block_sync_rx_pkg.sv
// Shared PCS definitions for the clause-49 block-lock receiver.
// Holds the lock FSM state encoding, the window defaults and the legal
// 64b/66b sync-header encodings.
package block_sync_rx_pkg;

  typedef enum logic [1:0] {
    ST_TEST      = 2'd0,
    ST_SLIP      = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } sync_state_t;

  localparam int SH_CNT_MAX_DEF     = 64;
  localparam int SH_INVALID_MAX_DEF = 16;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // A sync header is legal only if it is one of the two transition patterns.
  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_rx_sh_window_cnt.sv
// Sync-header test-window counters for block_sync_rx.
// Counts headers and invalid headers within one test window and flags the
// header that completes the window and the one that hits the invalid limit.
module sh_window_cnt
  import block_sync_rx_pkg::*;
#(
  parameter int SH_CNT_MAX     = SH_CNT_MAX_DEF,
  parameter int SH_INVALID_MAX = SH_INVALID_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic invalid,
  output logic window_done,
  output logic inv_limit,
  output logic inv_clean
);

  localparam int CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W = $clog2(SH_INVALID_MAX + 1);

  logic [CNT_W-1:0] sh_cnt;
  logic [INV_W-1:0] sh_inv_cnt;

  // Flags describe what the header presented this cycle does to the window.
  always_comb begin
    window_done = inc && (sh_cnt == CNT_W'(SH_CNT_MAX - 1));
    inv_limit   = inc && invalid && (sh_inv_cnt == INV_W'(SH_INVALID_MAX - 1));
    inv_clean   = (sh_inv_cnt == '0) && !invalid;
  end

  // Saturating window counters; a clear from the FSM wins over counting.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sh_cnt     <= '0;
      sh_inv_cnt <= '0;
    end else if (inc) begin
      if (sh_cnt != CNT_W'(SH_CNT_MAX)) begin
        sh_cnt <= sh_cnt + CNT_W'(1);
      end
      if (invalid && (sh_inv_cnt != INV_W'(SH_INVALID_MAX))) begin
        sh_inv_cnt <= sh_inv_cnt + INV_W'(1);
      end
    end
  end

endmodule

// File: rtl/block_sync_rx.sv
// Clause-49 block-lock receiver: tests sync headers from the gearbox,
// requests bit slips until a clean window is seen, and reports block lock.
// Optional feature: define BLOCK_SYNC_SLIP_CNT_EN to add slip_cnt_o, a
// saturating 8-bit count of slip pulses since reset.
module block_sync_rx
  import block_sync_rx_pkg::*;
#(
  parameter int HEAD_W         = 2,
  parameter int SH_CNT_MAX     = SH_CNT_MAX_DEF,
  parameter int SH_INVALID_MAX = SH_INVALID_MAX_DEF,
  parameter int SLIP_WAIT_N    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  output logic              slip_v_o,
  output logic              lock_v_o
`ifdef BLOCK_SYNC_SLIP_CNT_EN
  ,
  output logic [7:0]        slip_cnt_o
`endif
);

  localparam int WAIT_W = (SLIP_WAIT_N > 0) ? $clog2(SLIP_WAIT_N + 1) : 1;

  sync_state_t       state, state_n;
  logic              lock_n, slip_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic              cnt_clear, cnt_inc;
  logic              head_bad;
  logic              window_done, inv_limit, inv_clean;

  assign head_bad = !sh_is_valid(head_i[1:0]);

  sh_window_cnt #(
    .SH_CNT_MAX    (SH_CNT_MAX),
    .SH_INVALID_MAX(SH_INVALID_MAX)
  ) u_window (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .invalid    (head_bad),
    .window_done(window_done),
    .inv_limit  (inv_limit),
    .inv_clean  (inv_clean)
  );

  // Next-state and registered-output decisions for the lock FSM.
  always_comb begin
    state_n   = state;
    lock_n    = lock_v_o;
    slip_n    = 1'b0;
    wait_n    = wait_cnt;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      ST_TEST: begin
        if (valid_i) begin
          cnt_inc = 1'b1;
          if (head_bad && (!lock_v_o || inv_limit)) begin
            state_n   = ST_SLIP;
            lock_n    = 1'b0;
            slip_n    = 1'b1;
            cnt_clear = 1'b1;
          end else if (window_done) begin
            cnt_clear = 1'b1;
            if (inv_clean) begin
              lock_n = 1'b1;
            end
          end
        end
      end
      ST_SLIP: begin
        wait_n  = '0;
        state_n = (SLIP_WAIT_N == 0) ? ST_TEST : ST_SLIP_WAIT;
      end
      ST_SLIP_WAIT: begin
        if (valid_i) begin
          if (wait_cnt == WAIT_W'(SLIP_WAIT_N - 1)) begin
            state_n = ST_TEST;
            wait_n  = '0;
          end else begin
            wait_n = wait_cnt + WAIT_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_TEST;
      end
    endcase
  end

  // State and output registers; reset drops lock and any pending slip.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_TEST;
      lock_v_o <= 1'b0;
      slip_v_o <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      lock_v_o <= lock_n;
      slip_v_o <= slip_n;
      wait_cnt <= wait_n;
    end
  end

`ifdef BLOCK_SYNC_SLIP_CNT_EN
  // Saturating count of slip pulses, advancing on the edge that raises slip.
  always_ff @(posedge clk) begin
    if (reset) begin
      slip_cnt_o <= 8'd0;
    end else if (slip_n && (slip_cnt_o != 8'hFF)) begin
      slip_cnt_o <= slip_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_sync_rx.sv
// Self-checking bench for block_sync_rx with a per-cycle scoreboard.
// Build with BLOCK_SYNC_SLIP_CNT_EN defined to also check slip_cnt_o.
module tb_block_sync_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_i = 1'b0;
  logic [1:0] head_i = 2'b00;
  logic       slip_v_o;
  logic       lock_v_o;
`ifdef BLOCK_SYNC_SLIP_CNT_EN
  logic [7:0] slip_cnt_o;
`endif

  typedef struct packed {
    logic       lock;
    logic       slip;
    logic [7:0] scnt;
  } exp_t;

  exp_t sb_q[$];

  int assert_cnt = 0;
  int fail_cnt   = 0;

  int m_state = 0;
  int m_sh = 0;
  int m_inv = 0;
  int m_wait = 0;
  int m_slip_cnt = 0;
  bit m_lock = 1'b0;
  bit m_slip = 1'b0;

  always #5 clk = ~clk;

  block_sync_rx dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .head_i  (head_i),
    .slip_v_o(slip_v_o),
    .lock_v_o(lock_v_o)
`ifdef BLOCK_SYNC_SLIP_CNT_EN
    ,
    .slip_cnt_o(slip_cnt_o)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference behaviour of the lock function: state 0 test, 1 slip, 2 wait.
  task automatic modelStep(input logic rst, input logic vld, input logic [1:0] hd);
    bit bad;
    if (rst) begin
      m_state = 0; m_sh = 0; m_inv = 0; m_wait = 0;
      m_lock = 1'b0; m_slip = 1'b0; m_slip_cnt = 0;
    end else begin
      m_slip = 1'b0;
      case (m_state)
        1: begin
          m_state = 2;
          m_wait  = 0;
        end
        2: begin
          if (vld) begin
            m_wait++;
            if (m_wait == 2) m_state = 0;
          end
        end
        default: begin
          if (vld) begin
            m_sh++;
            bad = (hd == 2'b00) || (hd == 2'b11);
            if (bad) m_inv++;
            if (bad && (!m_lock || m_inv == 16)) begin
              m_state = 1; m_lock = 1'b0; m_sh = 0; m_inv = 0; m_slip = 1'b1;
              if (m_slip_cnt < 255) m_slip_cnt++;
            end else if (m_sh == 64) begin
              if (m_inv == 0) m_lock = 1'b1;
              m_sh = 0; m_inv = 0;
            end
          end
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [1:0] hd);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset   = rst;
    valid_i = vld;
    head_i  = hd;
    modelStep(rst, vld, hd);
    e.lock = m_lock;
    e.slip = m_slip;
    e.scnt = 8'(m_slip_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checkOutput("lock", {31'd0, lock_v_o}, {31'd0, got.lock});
    checkOutput("slip", {31'd0, slip_v_o}, {31'd0, got.slip});
`ifdef BLOCK_SYNC_SLIP_CNT_EN
    checkOutput("slip_cnt", {24'd0, slip_cnt_o}, {24'd0, got.scnt});
`endif
  endtask

  task automatic goodHeaders(input int n);
    logic [1:0] h;
    for (int i = 0; i < n; i++) begin
      h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      applyStimulus(1'b0, 1'b1, h);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b1, 2'b11);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int cyc;

    // Reset state
    doReset();
    checkOutput("reset_lock", {31'd0, lock_v_o}, 32'd0);
    checkOutput("reset_slip", {31'd0, slip_v_o}, 32'd0);

    // Lock acquisition with 64 clean headers
    goodHeaders(63);
    checkOutput("acq_lock63", {31'd0, lock_v_o}, 32'd0);
    goodHeaders(1);
    checkOutput("acq_lock64", {31'd0, lock_v_o}, 32'd1);

    // 15 invalid in a window keeps lock
    for (int i = 0; i < 64; i++)
      applyStimulus(1'b0, 1'b1, ((i % 4 == 3) && (i < 60)) ? 2'b11 : 2'b01);
    checkOutput("inv15_lock", {31'd0, lock_v_o}, 32'd1);

    // 16 invalid, the last on the window-closing header, drops lock
    for (int i = 0; i < 63; i++)
      applyStimulus(1'b0, 1'b1, (i % 4 == 3) ? 2'b00 : 2'b10);
    checkOutput("inv16_pre_lock", {31'd0, lock_v_o}, 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("inv16_lock", {31'd0, lock_v_o}, 32'd0);
    checkOutput("inv16_slip", {31'd0, slip_v_o}, 32'd1);
    applyStimulus(1'b0, 1'b1, 2'b01);
    checkOutput("inv16_slip_end", {31'd0, slip_v_o}, 32'd0);
    goodHeaders(2);

    // First header invalid: one slip, two discarded headers
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b11);
    checkOutput("first_bad_slip", {31'd0, slip_v_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("slip_one_cycle", {31'd0, slip_v_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b11);
    applyStimulus(1'b0, 1'b1, 2'b11);
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("wait_no_slip", {31'd0, slip_v_o}, 32'd0);
    checkOutput("wait_no_lock", {31'd0, lock_v_o}, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b11);
    checkOutput("test_resumed_slip", {31'd0, slip_v_o}, 32'd1);

    // Gearbox-style gaps during acquisition
    doReset();
    cnt = 0;
    cyc = 0;
    while (cnt < 64) begin
      cyc++;
      if (cyc % 33 == 0) begin
        applyStimulus(1'b0, 1'b0, 2'b11);
      end else begin
        applyStimulus(1'b0, 1'b1, 2'b10);
        cnt++;
        if (cnt == 63) checkOutput("gap_lock63", {31'd0, lock_v_o}, 32'd0);
      end
    end
    checkOutput("gap_lock64", {31'd0, lock_v_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("gap_hold_lock", {31'd0, lock_v_o}, 32'd1);

    // Reset during SLIP and mid-window
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("rst_slip_pre", {31'd0, slip_v_o}, 32'd1);
    applyStimulus(1'b1, 1'b1, 2'b01);
    checkOutput("rst_in_slip_slip", {31'd0, slip_v_o}, 32'd0);
    checkOutput("rst_in_slip_lock", {31'd0, lock_v_o}, 32'd0);
    goodHeaders(64);
    checkOutput("rst_relock", {31'd0, lock_v_o}, 32'd1);
    goodHeaders(30);
    applyStimulus(1'b1, 1'b1, 2'b01);
    checkOutput("rst_mid_lock", {31'd0, lock_v_o}, 32'd0);
    checkOutput("rst_mid_slip", {31'd0, slip_v_o}, 32'd0);
    goodHeaders(63);
    checkOutput("rst_fresh63", {31'd0, lock_v_o}, 32'd0);
    goodHeaders(1);
    checkOutput("rst_fresh64", {31'd0, lock_v_o}, 32'd1);

    // 300 forced slips
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b11);
      applyStimulus(1'b0, 1'b1, 2'b01);
      applyStimulus(1'b0, 1'b1, 2'b01);
      applyStimulus(1'b0, 1'b1, 2'b10);
    end
`ifdef BLOCK_SYNC_SLIP_CNT_EN
    checkOutput("slip_cnt_sat", {24'd0, slip_cnt_o}, 32'd255);
    doReset();
    checkOutput("slip_cnt_reset", {24'd0, slip_cnt_o}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
